shake_input_buffer: RTL and testbench

//  SIPO rate-block buffer between the load stage and the absorb stage of the SHAKE core.

---
 rtl/shake_pkg.sv | 31 +++
 rtl/shake_pad_word.sv | 38 +++
 rtl/shake_input_buffer.sv | 169 ++++++++++++++++
 tb/tb_shake_input_buffer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shake_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shake_pkg
// Purpose  : Shared types and constants for the SHAKE rate-block input buffer.
// Revision : 1.0 - initial release
// ============================================================================
package shake_pkg;

  typedef enum logic {
    SHAKE128 = 1'b0,
    SHAKE256 = 1'b1
  } shake_mode_t;

  localparam int RATE_WORDS_128 = 21;
  localparam int RATE_WORDS_256 = 17;

  localparam logic [7:0] PAD_DOMAIN = 8'h1F;
  localparam logic [7:0] PAD_FINAL  = 8'h80;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    FULL    = 2'd1,
    HANDOFF = 2'd2
  } ibuf_state_t;

  function automatic int rate_words(shake_mode_t mode);
    return (mode == SHAKE256) ? RATE_WORDS_256 : RATE_WORDS_128;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shake_pad_word.sv
`default_nettype none
// ============================================================================
// Module   : shake_pad_word
// Purpose  : Keeps the low byte_count_i bytes of data_i, drops in the domain
//            pad byte above them and optionally ORs the final pad bit.
// Revision : 1.0 - initial release
// ============================================================================
module shake_pad_word
  import shake_pkg::*;
#(
  parameter int W    = 64,
  parameter int BC_W = $clog2(W / 8)
) (
  input  logic [W-1:0]    data_i,
  input  logic [BC_W-1:0] byte_count_i,
  input  logic            final_word_i,
  output logic [W-1:0]    word_o
);

  localparam int BYTES = W / 8;

  always_comb begin
    word_o = '0;
    for (int k = 0; k < BYTES; k++) begin
      if (BC_W'(k) < byte_count_i) begin
        word_o[8*k +: 8] = data_i[8*k +: 8];
      end else if (BC_W'(k) == byte_count_i) begin
        word_o[8*k +: 8] = PAD_DOMAIN;
      end
    end
    // A 7-byte tail in the last rate word merges both pad bytes into 0x9F.
    if (final_word_i) begin
      word_o[W-8 +: 8] = word_o[W-8 +: 8] | PAD_FINAL;
    end
  end

endmodule
`default_nettype wire

// File: rtl/shake_input_buffer.sv
`default_nettype none
// ============================================================================
// Module   : shake_input_buffer
// Purpose  : SIPO rate-block buffer with built-in SHAKE padding and a
//            valid/ack handoff to the absorb stage.
// Revision : 1.0 - initial release
// ============================================================================
module shake_input_buffer
  import shake_pkg::*;
#(
  parameter int W         = 64,
  parameter int LEN_W     = 32,
  parameter int MAX_WORDS = 21
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   control_regs_enable,
  input  logic                   mode_i,
  input  logic [LEN_W-1:0]       input_length_i,
  input  logic                   load_enable,
  input  logic [W-1:0]           data_i,
  input  logic                   input_buffer_ready_wr,
  input  logic                   block_ack_i,
  output logic                   input_buffer_empty,
  output logic                   input_buffer_full,
  output logic                   last_input_block,
  output logic                   block_valid_o,
  output logic [MAX_WORDS*W-1:0] block_o
);

  localparam int IDX_W = $clog2(MAX_WORDS);
  localparam int BC_W  = $clog2(W / 8);

  ibuf_state_t                 state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [MAX_WORDS-1:0][W-1:0] storage_q, storage_d;
  logic [LEN_W-1:0]            remaining_q, remaining_d;
  logic                        armed_q, armed_d;
  logic                        last_q, last_d;
  shake_mode_t                 mode_q, mode_d;

  logic [IDX_W-1:0] rate_m1;
  logic             at_last_word;
  logic             rem_zero;
  logic             rem_partial;
  logic [BC_W-1:0]  pad_bytes;
  logic [W-1:0]     pad_word;
  logic             do_pad;

  assign rate_m1      = IDX_W'(rate_words(mode_q) - 1);
  assign at_last_word = (idx_q == rate_m1);
  assign rem_zero     = (remaining_q == '0);
  assign rem_partial  = !rem_zero && (remaining_q < LEN_W'(W / 8));
  // Low bits are the tail byte count when partial and zero when remaining is 0.
  assign pad_bytes    = remaining_q[BC_W-1:0];

  shake_pad_word #(
    .W    (W),
    .BC_W (BC_W)
  ) u_pad_word (
    .data_i       (data_i),
    .byte_count_i (pad_bytes),
    .final_word_i (at_last_word),
    .word_o       (pad_word)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    storage_d   = storage_q;
    remaining_d = remaining_q;
    armed_d     = armed_q;
    last_d      = last_q;
    mode_d      = mode_q;
    do_pad      = 1'b0;

    unique case (state_q)
      FILL: begin
        if (armed_q && rem_zero) begin
          do_pad = 1'b1;
        end else if (load_enable && armed_q) begin
          if (rem_partial) begin
            do_pad = 1'b1;
          end else begin
            storage_d[idx_q] = data_i;
            idx_d            = idx_q + 1'b1;
            remaining_d      = remaining_q - LEN_W'(W / 8);
            if (at_last_word) begin
              state_d = FULL;
            end
          end
        end

        if (do_pad) begin
          storage_d[idx_q] = pad_word;
          for (int i = 0; i < MAX_WORDS; i++) begin
            if ((IDX_W'(i) > idx_q) && (IDX_W'(i) <= rate_m1)) begin
              storage_d[i] = (IDX_W'(i) == rate_m1) ? {PAD_FINAL, {(W-8){1'b0}}}
                                                    : '0;
            end
          end
          remaining_d = '0;
          armed_d     = 1'b0;
          last_d      = 1'b1;
          state_d     = FULL;
        end
      end

      FULL: begin
        if (input_buffer_ready_wr) begin
          state_d = HANDOFF;
        end
      end

      HANDOFF: begin
        if (block_ack_i) begin
          state_d   = FILL;
          idx_d     = '0;
          storage_d = '0;
          last_d    = 1'b0;
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase

    // Header registers may be rewritten while a finished block is still held.
    if (control_regs_enable) begin
      mode_d      = shake_mode_t'(mode_i);
      remaining_d = input_length_i;
      armed_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      idx_q       <= '0;
      storage_q   <= '0;
      remaining_q <= '0;
      armed_q     <= 1'b0;
      last_q      <= 1'b0;
      mode_q      <= SHAKE128;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      storage_q   <= storage_d;
      remaining_q <= remaining_d;
      armed_q     <= armed_d;
      last_q      <= last_d;
      mode_q      <= mode_d;
    end
  end

  assign input_buffer_empty = (state_q == FILL) && (idx_q == '0);
  assign input_buffer_full  = (state_q == FULL) || (state_q == HANDOFF);
  assign block_valid_o      = (state_q == HANDOFF);
  assign last_input_block   = last_q;
  assign block_o            = storage_q;

  a_load_needs_header: assert property (
    @(posedge clk) disable iff (rst)
    (state_q == FILL && load_enable) |-> armed_q
  ) else $warning("shake_input_buffer: load_enable with no pending header, word dropped");

endmodule
`default_nettype wire

// File: tb/tb_shake_input_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shake_input_buffer
// Purpose  : Directed scoreboard bench for shake_input_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shake_input_buffer;
  import shake_pkg::*;

  localparam int W         = 64;
  localparam int LEN_W     = 32;
  localparam int MAX_WORDS = 21;
  localparam int BW        = MAX_WORDS * W;
  localparam logic [W-1:0] W_DOM = 64'h0000_0000_0000_001F;
  localparam logic [W-1:0] W_FIN = 64'h8000_0000_0000_0000;

  typedef struct packed {
    logic          last;
    logic [BW-1:0] blk;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             control_regs_enable;
  logic             mode_i;
  logic [LEN_W-1:0] input_length_i;
  logic             load_enable;
  logic [W-1:0]     data_i;
  logic             input_buffer_ready_wr;
  logic             block_ack_i;
  logic             input_buffer_empty;
  logic             input_buffer_full;
  logic             last_input_block;
  logic             block_valid_o;
  logic [BW-1:0]    block_o;

  exp_t sb_q[$];
  exp_t mon_exp;
  exp_t e;
  logic [BW-1:0] held;
  logic mon_seen;
  int n_checks = 0;
  int n_fail   = 0;

  shake_input_buffer #(
    .W         (W),
    .LEN_W     (LEN_W),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .control_regs_enable   (control_regs_enable),
    .mode_i                (mode_i),
    .input_length_i        (input_length_i),
    .load_enable           (load_enable),
    .data_i                (data_i),
    .input_buffer_ready_wr (input_buffer_ready_wr),
    .block_ack_i           (block_ack_i),
    .input_buffer_empty    (input_buffer_empty),
    .input_buffer_full     (input_buffer_full),
    .last_input_block      (last_input_block),
    .block_valid_o         (block_valid_o),
    .block_o               (block_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pat(int i);
    return {8{8'(i)}};
  endfunction

  task automatic check1(string name, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check_blk(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
    int bad;
    bad = -1;
    n_checks++;
    for (int i = 0; i < MAX_WORDS; i++) begin
      if (bad < 0 && act[W*i +: W] !== exp[W*i +: W]) bad = i;
    end
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s word%0d: got %016h expected %016h",
               name, bad, act[W*bad +: W], exp[W*bad +: W]);
    end
  endtask

  // Scoreboard monitor: one pop per handoff, on the first cycle valid is seen.
  initial mon_seen = 1'b0;
  always @(negedge clk) begin
    if (rst || !block_valid_o) begin
      mon_seen = 1'b0;
    end else if (!mon_seen) begin
      mon_seen = 1'b1;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_block: got valid block expected none");
      end else begin
        mon_exp = sb_q.pop_front();
        check_blk("block", block_o, mon_exp.blk);
        check1("block_last", last_input_block, mon_exp.last);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic header(logic mode, int len);
    control_regs_enable = 1'b1;
    mode_i              = mode;
    input_length_i      = LEN_W'(len);
    tick();
    control_regs_enable = 1'b0;
  endtask

  task automatic load(logic [W-1:0] d);
    load_enable = 1'b1;
    data_i      = d;
    tick();
    load_enable = 1'b0;
    data_i      = '0;
  endtask

  task automatic wait_full();
    int n;
    n = 0;
    while (!input_buffer_full && n < 50) begin
      tick();
      n++;
    end
    check1("wait_full", input_buffer_full, 1'b1);
  endtask

  task automatic commit();
    wait_full();
    input_buffer_ready_wr = 1'b1;
    tick();
    input_buffer_ready_wr = 1'b0;
    check1("valid_after_ready", block_valid_o, 1'b1);
  endtask

  task automatic ack();
    block_ack_i = 1'b1;
    tick();
    block_ack_i = 1'b0;
    check1("empty_after_ack", input_buffer_empty, 1'b1);
    check1("valid_after_ack", block_valid_o, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    control_regs_enable = 1'b0;
    mode_i = 1'b0;
    input_length_i = '0;
    load_enable = 1'b0;
    data_i = '0;
    input_buffer_ready_wr = 1'b0;
    block_ack_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check1("rst_empty", input_buffer_empty, 1'b1);
    check1("rst_full", input_buffer_full, 1'b0);
    check1("rst_valid", block_valid_o, 1'b0);
    check1("rst_last", last_input_block, 1'b0);

    // T1: SHAKE128 empty message, pad-only block one cycle after header.
    header(1'b0, 0);
    tick();
    check1("t1_full", input_buffer_full, 1'b1);
    check1("t1_last", last_input_block, 1'b1);
    e = '0;
    e.last = 1'b1;
    e.blk[W*0 +: W]  = W_DOM;
    e.blk[W*20 +: W] = W_FIN;
    sb_q.push_back(e);
    commit();
    ack();

    // T2: SHAKE256, 20 bytes: two full words plus a 4-byte tail.
    header(1'b1, 20);
    load(64'h0123_4567_89AB_CDEF);
    load(64'hFEDC_BA98_7654_3210);
    load(64'h8877_6655_4433_2211);
    check1("t2_full_latency", input_buffer_full, 1'b1);
    e = '0;
    e.last = 1'b1;
    e.blk[W*0 +: W]  = 64'h0123_4567_89AB_CDEF;
    e.blk[W*1 +: W]  = 64'hFEDC_BA98_7654_3210;
    e.blk[W*2 +: W]  = 64'h0000_001F_4433_2211;
    e.blk[W*16 +: W] = W_FIN;
    sb_q.push_back(e);
    commit();
    ack();

    // T3: exact SHAKE256 rate, then a pad-only follow-up block.
    header(1'b1, 136);
    e = '0;
    e.last = 1'b0;
    for (int i = 0; i < 17; i++) begin
      load(pat(i + 1));
      e.blk[W*i +: W] = pat(i + 1);
    end
    check1("t3_full", input_buffer_full, 1'b1);
    check1("t3_last", last_input_block, 1'b0);
    sb_q.push_back(e);
    e = '0;
    e.last = 1'b1;
    e.blk[W*0 +: W]  = W_DOM;
    e.blk[W*16 +: W] = W_FIN;
    sb_q.push_back(e);
    commit();
    ack();
    tick();
    check1("t3_pad_full", input_buffer_full, 1'b1);
    check1("t3_pad_last", last_input_block, 1'b1);
    commit();
    ack();

    // T4/T5: SHAKE128, 167 bytes; 7-byte tail in the last word, long hold.
    header(1'b0, 167);
    e = '0;
    e.last = 1'b1;
    for (int i = 0; i < 20; i++) begin
      load(pat(i + 8'h40));
      e.blk[W*i +: W] = pat(i + 8'h40);
    end
    load(64'hAABB_CCDD_EEFF_0011);
    e.blk[W*20 +: W] = 64'h9FBB_CCDD_EEFF_0011;
    sb_q.push_back(e);
    commit();
    held = block_o;
    input_buffer_ready_wr = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check1("t5_valid_hold", block_valid_o, 1'b1);
      check_blk("t5_block_hold", block_o, held);
    end
    input_buffer_ready_wr = 1'b0;
    check1("t5_last_hold", last_input_block, 1'b1);
    ack();

    // T6: reset mid-block discards everything, loads ignored until header.
    header(1'b0, 100);
    for (int i = 0; i < 5; i++) load(pat(i + 8'hC0));
    check1("t6_not_empty", input_buffer_empty, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check1("t6_rst_empty", input_buffer_empty, 1'b1);
    check1("t6_rst_full", input_buffer_full, 1'b0);
    check1("t6_rst_valid", block_valid_o, 1'b0);
    for (int i = 0; i < 3; i++) load(pat(i + 8'hD0));
    check1("t6_ignored_empty", input_buffer_empty, 1'b1);
    check1("t6_ignored_full", input_buffer_full, 1'b0);
    header(1'b1, 0);
    e = '0;
    e.last = 1'b1;
    e.blk[W*0 +: W]  = W_DOM;
    e.blk[W*16 +: W] = W_FIN;
    sb_q.push_back(e);
    commit();
    ack();

    // T7: SHAKE256, 128 bytes: autopad lands on the last rate word.
    header(1'b1, 128);
    e = '0;
    e.last = 1'b1;
    for (int i = 0; i < 16; i++) begin
      load(pat(i + 8'h80));
      e.blk[W*i +: W] = pat(i + 8'h80);
    end
    e.blk[W*16 +: W] = 64'h8000_0000_0000_001F;
    sb_q.push_back(e);
    commit();
    ack();

    tick();
    tick();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drained: got %0d pending expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
